pr_write_buffer: RTL

//  Write-side counterpart of the PageRank read buffer: packs WIDTH-bit elements
//  (e.g. updated rank values) into one FULL_WIDTH-bit memory line and issues a

---
 rtl/pr_write_buffer.sv | 104 ++++++++++
 1 files changed

// File: rtl/pr_write_buffer.sv
// Packs WIDTH-bit elements into one FULL_WIDTH-bit line, then issues a single
// masked wide write. The FILL state collects elements and the DRAIN state holds the write until it is accepted.
module pr_write_buffer #(
    parameter int FULL_WIDTH = 512,
    parameter int WIDTH      = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        idata_valid,
    input  logic [WIDTH-1:0]            idata,
    input  logic [ADDR_WIDTH-1:0]       iaddr,
    input  logic [7:0]                  base,
    input  logic                        flush,
    output logic                        idata_ready,
    output logic                        wvalid,
    input  logic                        wready,
    output logic [FULL_WIDTH-1:0]       wdata,
    output logic [FULL_WIDTH/WIDTH-1:0] wmask,
    output logic [ADDR_WIDTH-1:0]       waddr
);

    localparam int         MAX_ELEMS = FULL_WIDTH / WIDTH;
    localparam logic [8:0] LP_MAX    = 9'(MAX_ELEMS);
    localparam logic [7:0] LP_LAST   = 8'(MAX_ELEMS - 1);

    typedef enum logic {S_FILL, S_DRAIN} state_t;

    state_t                  r_state;
    logic                    r_wvalid;
    logic [FULL_WIDTH-1:0]   r_wdata;
    logic [MAX_ELEMS-1:0]    r_wmask;
    logic [ADDR_WIDTH-1:0]   r_waddr;
    logic [7:0]              r_ptr;

    logic                    w_accept;
    logic                    w_empty;
    logic [7:0]              w_ptr;
    logic                    w_close;

    // The line counts as empty while no mask bit is set, so the mask doubles as the fill flag.
    always_comb begin
        w_empty  = (r_wmask == '0);
        w_accept = idata_valid && idata_ready;
        w_ptr    = r_ptr;
        if (w_empty) begin
            w_ptr = ({1'b0, base} < LP_MAX) ? base : 8'd0;
        end
        if (w_accept) begin
            w_close = (w_ptr == LP_LAST) || flush;
        end else begin
            w_close = (r_state == S_FILL) && flush && !w_empty;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_FILL;
            r_wvalid <= 1'b0;
            r_wdata  <= '0;
            r_wmask  <= '0;
            r_waddr  <= '0;
            r_ptr    <= 8'd0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        if (w_empty) begin
                            r_waddr <= iaddr;
                        end
                        for (int k = 0; k < MAX_ELEMS; k++) begin
                            if (w_ptr == 8'(k)) begin
                                r_wdata[FULL_WIDTH-1-k*WIDTH -: WIDTH] <= idata;
                                r_wmask[k] <= 1'b1;
                            end
                        end
                        r_ptr <= 8'(w_ptr + 8'd1);
                    end
                    if (w_close) begin
                        r_state  <= S_DRAIN;
                        r_wvalid <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (wready) begin
                        r_state  <= S_FILL;
                        r_wvalid <= 1'b0;
                        r_wdata  <= '0;
                        r_wmask  <= '0;
                        r_ptr    <= 8'd0;
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    assign idata_ready = (r_state == S_FILL) && !rst;
    assign wvalid      = r_wvalid;
    assign wdata       = r_wdata;
    assign wmask       = r_wmask;
    assign waddr       = r_waddr;

endmodule
